// File: rtl/lsu_rmw_seq.sv
// Read-modify-write sequencer between the LSU and a word-only, checksum-protected data memory.
// Sub-word stores become a read phase, a byte merge and a write phase; everything else is one phase.
module lsu_rmw_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_req_val_i,
  output logic        s_req_rdy_o,
  input  logic        s_req_we_i,
  input  logic [3:0]  s_req_be_i,
  input  logic [31:0] s_req_add_i,
  input  logic [31:0] s_req_wdata_i,
  output logic        s_rsp_val_o,
  output logic [31:0] s_rsp_rdata_o,
  output logic        s_rsp_err_o,
  output logic        m_req_o,
  input  logic        m_gnt_i,
  output logic        m_we_o,
  output logic [31:0] m_add_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i,
  input  logic        m_err_i,
  output logic [1:0]  s_state_o
);

  typedef enum logic [1:0] {
    LSU_RMW_IDLE  = 2'b00,
    LSU_RMW_READ  = 2'b01,
    LSU_RMW_WRITE = 2'b10
  } lsu_rmw_state_e;

  typedef enum logic [1:0] {
    PH_REQ   = 2'b00,
    PH_RSP   = 2'b01,
    PH_MERGE = 2'b10
  } phase_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_rmw_state_e state_q, state_d;
  phase_e         phase_q, phase_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [3:0]     be_q, be_d;
  logic [29:0]    add_q, add_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           m_req_q, m_req_d;
  logic           m_we_q, m_we_d;
  logic [31:0]    m_wdata_q, m_wdata_d;
  logic           rsp_val_q, rsp_val_d;
  logic           rsp_err_q, rsp_err_d;
  logic [31:0]    rsp_rdata_q, rsp_rdata_d;
  logic           accept;
  logic           rsp_hit;
  logic [31:0]    merged;

  assign s_req_rdy_o = (state_q == LSU_RMW_IDLE) && s_resetn_i;
  assign accept      = s_req_val_i && s_req_rdy_o;
  // A grant and response in the same request cycle completes the phase at once.
  assign rsp_hit     = m_rvalid_i && ((phase_q == PH_RSP) || ((phase_q == PH_REQ) && m_gnt_i));

  always_comb begin
    merged = m_rdata_i;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    be_d        = be_q;
    add_d       = add_q;
    wdata_d     = wdata_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_wdata_d   = m_wdata_q;
    rsp_val_d   = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      LSU_RMW_IDLE: begin
        if (accept) begin
          we_d    = s_req_we_i;
          be_d    = s_req_be_i;
          add_d   = s_req_add_i[31:2];
          wdata_d = s_req_wdata_i;
          phase_d = PH_REQ;
          cnt_d   = '0;
          if (s_req_we_i && (s_req_be_i == '0)) begin
            rsp_val_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (s_req_we_i && (s_req_be_i == '1)) begin
            state_d   = LSU_RMW_WRITE;
            m_req_d   = 1'b1;
            m_we_d    = 1'b1;
            m_wdata_d = s_req_wdata_i;
          end else begin
            state_d = LSU_RMW_READ;
            m_req_d = 1'b1;
            m_we_d  = 1'b0;
          end
        end
      end
      LSU_RMW_READ, LSU_RMW_WRITE: begin
        if (phase_q == PH_MERGE) begin
          // Merged word was registered on the read response; issue the write now.
          m_req_d = 1'b1;
          m_we_d  = 1'b1;
          phase_d = PH_REQ;
          cnt_d   = '0;
        end else if (rsp_hit) begin
          m_req_d = 1'b0;
          cnt_d   = '0;
          if (state_q == LSU_RMW_WRITE) begin
            state_d     = LSU_RMW_IDLE;
            m_we_d      = 1'b0;
            rsp_val_d   = 1'b1;
            rsp_err_d   = m_err_i;
            rsp_rdata_d = '0;
          end else if (m_err_i) begin
            state_d   = LSU_RMW_IDLE;
            rsp_val_d = 1'b1;
            rsp_err_d = 1'b1;
            if (we_q) rsp_rdata_d = '0;
          end else if (!we_q) begin
            state_d     = LSU_RMW_IDLE;
            rsp_val_d   = 1'b1;
            rsp_rdata_d = m_rdata_i;
          end else begin
            state_d   = LSU_RMW_WRITE;
            phase_d   = PH_MERGE;
            m_wdata_d = merged;
          end
        end else if ((phase_q == PH_REQ) && m_gnt_i) begin
          m_req_d = 1'b0;
          phase_d = PH_RSP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = LSU_RMW_IDLE;
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          rsp_val_d = 1'b1;
          rsp_err_d = 1'b1;
          if (we_q) rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = LSU_RMW_IDLE;
        m_req_d   = 1'b0;
        m_we_d    = 1'b0;
        rsp_val_d = 1'b1;
        rsp_err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_q     <= LSU_RMW_IDLE;
      phase_q     <= PH_REQ;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      add_q       <= '0;
      wdata_q     <= '0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_wdata_q   <= '0;
      rsp_val_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      be_q        <= be_d;
      add_q       <= add_d;
      wdata_q     <= wdata_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_wdata_q   <= m_wdata_d;
      rsp_val_q   <= rsp_val_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign s_rsp_val_o   = rsp_val_q;
  assign s_rsp_err_o   = rsp_err_q;
  assign s_rsp_rdata_o = rsp_rdata_q;
  assign m_req_o       = m_req_q;
  assign m_we_o        = m_we_q;
  assign m_add_o       = {add_q, 2'b00};
  assign m_wdata_o     = m_wdata_q;
  assign s_state_o     = state_q;

endmodule

// File: tb/tb_lsu_rmw_seq.sv
// Bench for lsu_rmw_seq: a memory responder with programmable delays/faults and a
// word-level reference memory that predicts load data, merged stores and latency.
module tb_lsu_rmw_seq;

  logic        s_clk_i = 1'b0;
  logic        s_resetn_i;
  logic        s_req_val_i;
  logic        s_req_rdy_o;
  logic        s_req_we_i;
  logic [3:0]  s_req_be_i;
  logic [31:0] s_req_add_i;
  logic [31:0] s_req_wdata_i;
  logic        s_rsp_val_o;
  logic [31:0] s_rsp_rdata_o;
  logic        s_rsp_err_o;
  logic        m_req_o;
  logic        m_gnt_i;
  logic        m_we_o;
  logic [31:0] m_add_o;
  logic [31:0] m_wdata_o;
  logic        m_rvalid_i;
  logic [31:0] m_rdata_i;
  logic        m_err_i;
  logic [1:0]  s_state_o;

  lsu_rmw_seq #(.TIMEOUT(4)) dut (
    .s_clk_i(s_clk_i), .s_resetn_i(s_resetn_i),
    .s_req_val_i(s_req_val_i), .s_req_rdy_o(s_req_rdy_o), .s_req_we_i(s_req_we_i),
    .s_req_be_i(s_req_be_i), .s_req_add_i(s_req_add_i), .s_req_wdata_i(s_req_wdata_i),
    .s_rsp_val_o(s_rsp_val_o), .s_rsp_rdata_o(s_rsp_rdata_o), .s_rsp_err_o(s_rsp_err_o),
    .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_we_o(m_we_o), .m_add_o(m_add_o),
    .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .m_err_i(m_err_i), .s_state_o(s_state_o)
  );

  initial forever #5 s_clk_i = ~s_clk_i;

  int          vectors = 0;
  int          miscompares = 0;
  int          n_rd = 0, n_wr = 0, req_cycles = 0, delay_sum = 0;
  logic [31:0] last_add = '0, last_wdata = '0;
  bit          hang = 0, rand_delays = 0, combined = 0, err_next = 0, stray = 0;
  logic [31:0] bus_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  logic [1:0]  st_trace [$];

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return ({2'b00, w} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  task automatic set_word(input logic [31:0] addr, input logic [31:0] v);
    bus_mem[addr[31:2]] = v;
    ref_mem[addr[31:2]] = v;
  endtask

  // Memory responder: grants after a delay, returns data/err after a second delay.
  initial begin : responder
    bit          pend = 0, waiting = 0, pend_err = 0;
    int          g_cnt = 0, rv_cnt = 0;
    logic [31:0] pend_data = '0;
    logic [29:0] w;
    m_gnt_i = 0; m_rvalid_i = 0; m_err_i = 0; m_rdata_i = '0;
    forever begin
      @(negedge s_clk_i);
      m_gnt_i = 0; m_rvalid_i = 0; m_err_i = 0; m_rdata_i = $urandom;
      if (!s_resetn_i) begin
        pend = 0; waiting = 0;
      end else if (stray) begin
        m_rvalid_i = 1; m_err_i = 1; stray = 0;
      end else if (pend) begin
        if (rv_cnt == 0) begin
          m_rvalid_i = 1; m_rdata_i = pend_data; m_err_i = pend_err; pend = 0;
        end else rv_cnt--;
      end else if (m_req_o) begin
        req_cycles++;
        if (!waiting) begin
          waiting = 1;
          g_cnt = rand_delays ? int'($urandom_range(0, 2)) : 0;
          delay_sum += g_cnt;
        end
        if (!hang) begin
          if (g_cnt == 0) begin
            m_gnt_i = 1; waiting = 0; last_add = m_add_o;
            w = m_add_o[31:2];
            pend_data = bus_mem.exists(w) ? bus_mem[w] : init_word(w);
            if (m_we_o) begin
              n_wr++; last_wdata = m_wdata_o; bus_mem[w] = m_wdata_o; pend_data = $urandom;
            end else n_rd++;
            pend_err = err_next; err_next = 0;
            rv_cnt = rand_delays ? int'($urandom_range(0, 2)) : 0;
            delay_sum += rv_cnt;
            if (combined && rv_cnt == 0) begin
              m_rvalid_i = 1; m_rdata_i = pend_data; m_err_i = pend_err;
            end else pend = 1;
          end else g_cnt--;
        end
      end else waiting = 0;
    end
  end

  task automatic do_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic got,
                        output logic err, output logic [31:0] rd);
    @(negedge s_clk_i);
    delay_sum = 0;
    st_trace.delete();
    st_trace.push_back(s_state_o);
    s_req_val_i = 1; s_req_we_i = we; s_req_be_i = be; s_req_add_i = addr; s_req_wdata_i = wd;
    @(negedge s_clk_i);
    s_req_val_i = 0;
    lat = 1; got = 0; err = 0; rd = '0;
    while (1) begin
      if (st_trace[$] !== s_state_o) st_trace.push_back(s_state_o);
      if (s_rsp_val_o) begin
        got = 1; err = s_rsp_err_o; rd = s_rsp_rdata_o;
        break;
      end
      if (lat >= 40) break;
      @(negedge s_clk_i);
      lat++;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL rsp_wait: no s_rsp_val_o within %0d cycles, required one", lat);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({s_req_rdy_o, s_rsp_val_o, s_rsp_err_o, m_req_o, m_we_o, s_state_o} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: rdy/val/err/req/we/state=%b required 0", {s_req_rdy_o, s_rsp_val_o, s_rsp_err_o, m_req_o, m_we_o, s_state_o});
    end
    vectors++;
    if ({s_rsp_rdata_o, m_add_o, m_wdata_o} !== 96'b0) begin
      miscompares++;
      $display("FAIL reset_data: rdata=%h add=%h wdata=%h required 0", s_rsp_rdata_o, m_add_o, m_wdata_o);
    end
    @(negedge s_clk_i);
    s_resetn_i = 1;
    #1;
    vectors++;
    if (s_req_rdy_o !== 1'b1) begin
      miscompares++; $display("FAIL reset_rdy: got %b required 1", s_req_rdy_o);
    end
  endtask

  task automatic test_load();
    int lat; logic got, err; logic [31:0] rd; int w0 = n_wr, r0 = n_rd;
    set_word(32'h80000004, 32'hDEADBEEF);
    do_txn(1'b0, 4'h0, 32'h80000006, 32'h0, lat, got, err, rd);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL load_latency: got %0d required 3", lat); end
    vectors++; if (last_add !== 32'h80000004) begin miscompares++; $display("FAIL load_addr: got %h required 80000004", last_add); end
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_rdata: got %h required deadbeef", rd); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL load_err: got %b required 0", err); end
    vectors++; if (n_wr - w0 !== 0 || n_rd - r0 !== 1) begin miscompares++; $display("FAIL load_phases: reads %0d writes %0d required 1 0", n_rd - r0, n_wr - w0); end
  endtask

  task automatic test_rmw();
    int lat; logic got, err; logic [31:0] rd; logic [7:0] tr; int w0 = n_wr, r0 = n_rd;
    set_word(32'h10000010, 32'h11223344);
    do_txn(1'b1, 4'b0010, 32'h10000010, 32'h0000AB00, lat, got, err, rd);
    tr = (st_trace.size() == 4) ? {st_trace[0], st_trace[1], st_trace[2], st_trace[3]} : 8'hFF;
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL rmw_latency: got %0d required 6", lat); end
    vectors++; if (last_wdata !== 32'h1122AB44) begin miscompares++; $display("FAIL rmw_wdata: got %h required 1122ab44", last_wdata); end
    vectors++; if (tr !== 8'b00_01_10_00) begin miscompares++; $display("FAIL rmw_states: got %b required 00011000", tr); end
    vectors++; if (n_rd - r0 !== 1 || n_wr - w0 !== 1) begin miscompares++; $display("FAIL rmw_phases: reads %0d writes %0d required 1 1", n_rd - r0, n_wr - w0); end
    vectors++; if (err !== 1'b0 || rd !== 32'h0) begin miscompares++; $display("FAIL rmw_rsp: err %b rdata %h required 0 0", err, rd); end
  endtask

  task automatic test_full_store();
    int lat; logic got, err; logic [31:0] rd; int w0 = n_wr, r0 = n_rd;
    do_txn(1'b1, 4'hF, 32'h10000023, 32'hCAFEF00D, lat, got, err, rd);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL full_latency: got %0d required 3", lat); end
    vectors++; if (n_rd - r0 !== 0 || n_wr - w0 !== 1) begin miscompares++; $display("FAIL full_phases: reads %0d writes %0d required 0 1", n_rd - r0, n_wr - w0); end
    vectors++; if (last_wdata !== 32'hCAFEF00D || last_add !== 32'h10000020) begin miscompares++; $display("FAIL full_bus: wdata %h add %h required cafef00d 10000020", last_wdata, last_add); end
  endtask

  task automatic test_zero_be();
    int lat; logic got, err; logic [31:0] rd; int w0 = n_wr, r0 = n_rd;
    do_txn(1'b1, 4'h0, 32'h10000030, 32'h12345678, lat, got, err, rd);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL zbe_latency: got %0d required 1", lat); end
    vectors++; if (n_rd - r0 !== 0 || n_wr - w0 !== 0 || err !== 1'b0) begin miscompares++; $display("FAIL zbe_bus: reads %0d writes %0d err %b required 0 0 0", n_rd - r0, n_wr - w0, err); end
  endtask

  task automatic test_rd_err();
    int lat; logic got, err; logic [31:0] rd; int w0 = n_wr;
    err_next = 1;
    do_txn(1'b1, 4'b0100, 32'h10000040, 32'h00550000, lat, got, err, rd);
    repeat (4) @(negedge s_clk_i);
    vectors++; if (err !== 1'b1 || lat !== 3) begin miscompares++; $display("FAIL rderr_rsp: err %b lat %0d required 1 3", err, lat); end
    vectors++; if (n_wr - w0 !== 0 || s_state_o !== 2'b00) begin miscompares++; $display("FAIL rderr_nowrite: writes %0d state %b required 0 00", n_wr - w0, s_state_o); end
  endtask

  task automatic test_same_cycle();
    int lat; logic got, err; logic [31:0] rd;
    combined = 1;
    set_word(32'h10000050, 32'hA1B2C3D4);
    do_txn(1'b0, 4'h0, 32'h10000052, 32'h0, lat, got, err, rd);
    vectors++; if (lat !== 2 || rd !== 32'hA1B2C3D4) begin miscompares++; $display("FAIL same_load: lat %0d rdata %h required 2 a1b2c3d4", lat, rd); end
    do_txn(1'b1, 4'b1001, 32'h10000050, 32'h77000088, lat, got, err, rd);
    vectors++; if (lat !== 4 || last_wdata !== 32'h77B2C388) begin miscompares++; $display("FAIL same_rmw: lat %0d wdata %h required 4 77b2c388", lat, last_wdata); end
    combined = 0;
  endtask

  task automatic test_timeout();
    int lat; logic got, err; logic [31:0] rd; bit seen = 0;
    hang = 1; req_cycles = 0;
    do_txn(1'b0, 4'h0, 32'h10000060, 32'h0, lat, got, err, rd);
    vectors++; if (req_cycles !== 4) begin miscompares++; $display("FAIL to_req_cycles: got %0d required 4", req_cycles); end
    vectors++; if (err !== 1'b1 || lat !== 5 || m_req_o !== 1'b0) begin miscompares++; $display("FAIL to_rsp: err %b lat %0d req %b required 1 5 0", err, lat, m_req_o); end
    hang = 0; stray = 1;
    repeat (3) begin @(negedge s_clk_i); if (s_rsp_val_o) seen = 1; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL to_stray: rsp seen %b required 0", seen); end
    set_word(32'h10000060, 32'h0BADF00D);
    do_txn(1'b0, 4'h0, 32'h10000060, 32'h0, lat, got, err, rd);
    vectors++; if (err !== 1'b0 || rd !== 32'h0BADF00D || lat !== 3) begin miscompares++; $display("FAIL to_recover: err %b rdata %h lat %0d required 0 0badf00d 3", err, rd, lat); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    hang = 1;
    @(negedge s_clk_i);
    s_req_val_i = 1; s_req_we_i = 1; s_req_be_i = 4'hF; s_req_add_i = 32'h10000070; s_req_wdata_i = 32'h5555AAAA;
    @(negedge s_clk_i);
    s_req_val_i = 0;
    vectors++; if (s_state_o !== 2'b10 || m_req_o !== 1'b1) begin miscompares++; $display("FAIL rst_pre: state %b req %b required 10 1", s_state_o, m_req_o); end
    s_resetn_i = 0;
    #1;
    vectors++; if (m_req_o !== 1'b0 || s_state_o !== 2'b00 || s_req_rdy_o !== 1'b0) begin miscompares++; $display("FAIL rst_async: req %b state %b rdy %b required 0 00 0", m_req_o, s_state_o, s_req_rdy_o); end
    repeat (2) begin @(negedge s_clk_i); if (s_rsp_val_o) seen = 1; end
    s_resetn_i = 1;
    #1;
    vectors++; if (s_req_rdy_o !== 1'b1) begin miscompares++; $display("FAIL rst_rdy: got %b required 1", s_req_rdy_o); end
    hang = 0;
    repeat (3) begin @(negedge s_clk_i); if (s_rsp_val_o) seen = 1; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_norsp: rsp seen %b required 0", seen); end
  endtask

  task automatic test_random();
    int lat, exp_lat, phases, w0, r0;
    logic got, err, we; logic [31:0] rd, addr, wd, nw, exp_rd; logic [3:0] be; logic [29:0] w;
    rand_delays = 1;
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: be = 4'h0;
        1: be = 4'hF;
        default: be = 4'($urandom);
      endcase
      addr = 32'h20000000 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      wd = $urandom; w = addr[31:2];
      w0 = n_wr; r0 = n_rd;
      nw = ref_rd(w); exp_rd = '0;
      if (!we) begin phases = 1; exp_rd = nw; end
      else if (be == 4'h0) phases = 0;
      else if (be == 4'hF) begin phases = 1; nw = wd; end
      else begin
        phases = 2;
        for (int i = 0; i < 4; i++) if (be[i]) nw[8*i +: 8] = wd[8*i +: 8];
      end
      if (we && be != 4'h0) ref_mem[w] = nw;
      do_txn(we, be, addr, wd, lat, got, err, rd);
      exp_lat = (phases == 0) ? 1 : 3 * phases + delay_sum;
      vectors++; if (lat !== exp_lat || err !== 1'b0) begin miscompares++; $display("FAIL rnd_timing[%0d]: lat %0d err %b required %0d 0", n, lat, err, exp_lat); end
      vectors++; if (rd !== exp_rd) begin miscompares++; $display("FAIL rnd_rdata[%0d]: got %h required %h", n, rd, exp_rd); end
      vectors++; if (n_rd - r0 !== int'(!we || phases == 2) || n_wr - w0 !== int'(we && phases != 0)) begin
        miscompares++; $display("FAIL rnd_phases[%0d]: reads %0d writes %0d we %b be %b", n, n_rd - r0, n_wr - w0, we, be);
      end
      if (phases != 0) begin
        vectors++; if (last_add !== {addr[31:2], 2'b00}) begin miscompares++; $display("FAIL rnd_addr[%0d]: got %h required %h", n, last_add, {addr[31:2], 2'b00}); end
      end
      if (we && be != 4'h0) begin
        vectors++; if (bus_mem[w] !== ref_mem[w]) begin miscompares++; $display("FAIL rnd_mem[%0d]: got %h required %h", n, bus_mem[w], ref_mem[w]); end
      end
    end
    rand_delays = 0;
  endtask

  initial begin
    s_resetn_i = 0; s_req_val_i = 0; s_req_we_i = 0; s_req_be_i = '0;
    s_req_add_i = '0; s_req_wdata_i = '0;
    repeat (3) @(negedge s_clk_i);
    test_reset();
    test_load();
    test_rmw();
    test_full_store();
    test_zero_be();
    test_rd_err();
    test_same_cycle();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
